// File: rtl/dom_gf256_inv_front_if.sv
// Signal bundle for dom_gf256_inv_front: upstream byte/randomness handshake,
// shared GF(2^4) multiplier operand/product buses and the shared output nibble.
// "slave" is the front-stage view; "master" is the surrounding logic view.
interface dom_gf256_inv_front_if #(
   parameter int SHARES = 2
);
   localparam int ZW = 2 * SHARES * (SHARES - 1);

   logic [8*SHARES-1:0] _XxDI;
   logic                InValidxSI;
   logic                InReadyxSO;
   logic [ZW-1:0]       _RandZxDI;
   logic [4*SHARES-1:0] _RandBxDI;
   logic                RandValidxSI;
   logic                RandUsedxSO;
   logic [4*SHARES-1:0] _MulXxDO;
   logic [4*SHARES-1:0] _MulYxDO;
   logic [ZW-1:0]       _MulZxDO;
   logic [4*SHARES-1:0] _MulBxDO;
   logic [4*SHARES-1:0] _MulQxDI;
   logic [4*SHARES-1:0] _DxDO;
   logic                OutValidxSO;
   logic [15:0]         RandCntxDO;

   modport slave (
      input  _XxDI, InValidxSI, _RandZxDI, _RandBxDI, RandValidxSI, _MulQxDI,
      output InReadyxSO, RandUsedxSO, _MulXxDO, _MulYxDO, _MulZxDO, _MulBxDO,
             _DxDO, OutValidxSO, RandCntxDO
   );

   modport master (
      output _XxDI, InValidxSI, _RandZxDI, _RandBxDI, RandValidxSI, _MulQxDI,
      input  InReadyxSO, RandUsedxSO, _MulXxDO, _MulYxDO, _MulZxDO, _MulBxDO,
             _DxDO, OutValidxSO, RandCntxDO
   );
endinterface

// File: rtl/dom_gf256_inv_front.sv
// First stage of the masked GF(2^8) inversion of the DOM AES S-box.
// Splits every share into nibbles, feeds the external shared GF(2^4)
// multiplier, and adds the share-wise square-scale term to its product.
// Share i output depends only on share i data, its own pipeline and Q_i.
module dom_gf256_inv_front #(
   parameter int SHARES      = 2,
   parameter int MUL_LATENCY = 1
) (
   input  logic                 ClkxCI,
   input  logic                 RstxBI,
   dom_gf256_inv_front_if.slave io
);
   localparam int NW = 4 * SHARES;

   // Normal-basis N^2*nu square-scale map, linear, applied per share.
   function automatic logic [3:0] sq_scale(input logic [3:0] s);
      logic [3:0] q;
      q[3] = s[1] ^ s[0];
      q[2] = s[3] ^ s[0];
      q[1] = s[3];
      q[0] = s[3] ^ s[2];
      return q;
   endfunction

   logic                   acc_s;
   logic [NW-1:0]          q_new_s;
   logic [NW-1:0]          q_pipe_q [MUL_LATENCY];
   logic [NW-1:0]          q_pipe_d [MUL_LATENCY];
   logic [MUL_LATENCY-1:0] v_pipe_q;
   logic [MUL_LATENCY-1:0] v_pipe_d;
   logic [NW-1:0]          d_q;
   logic [NW-1:0]          d_d;
   logic                   out_valid_q;
   logic                   out_valid_d;
   logic [15:0]            rand_cnt_q;
   logic [15:0]            rand_cnt_d;

   // A byte is taken only together with fresh randomness.
   assign acc_s          = io.InValidxSI & io.RandValidxSI;
   assign io.InReadyxSO  = io.RandValidxSI;
   assign io.RandUsedxSO = acc_s;
   assign io._DxDO       = d_q;
   assign io.OutValidxSO = out_valid_q;
   assign io.RandCntxDO  = rand_cnt_q;

   // Multiplier operands: only an accepted byte outside reset reaches the multiplier.
   always_comb begin
      io._MulXxDO = '0;
      io._MulYxDO = '0;
      io._MulZxDO = '0;
      io._MulBxDO = '0;
      if (acc_s && RstxBI) begin
         for (int i = 0; i < SHARES; i++) begin
            io._MulXxDO[4*i +: 4] = io._XxDI[8*i+4 +: 4];
            io._MulYxDO[4*i +: 4] = io._XxDI[8*i +: 4];
         end
         io._MulZxDO = io._RandZxDI;
         io._MulBxDO = io._RandBxDI;
      end else begin
         io._MulXxDO = '0;
         io._MulYxDO = '0;
         io._MulZxDO = '0;
         io._MulBxDO = '0;
      end
   end

   // Square-scale term of hi^lo, computed separately for each share.
   always_comb begin
      q_new_s = '0;
      for (int i = 0; i < SHARES; i++) begin
         if (acc_s) begin
            q_new_s[4*i +: 4] = sq_scale(io._XxDI[8*i+4 +: 4] ^ io._XxDI[8*i +: 4]);
         end else begin
            q_new_s[4*i +: 4] = 4'h0;
         end
      end
   end

   // Alignment pipe: square-scale term and valid travel as deep as the multiplier.
   always_comb begin
      q_pipe_d[0] = q_new_s;
      v_pipe_d    = '0;
      v_pipe_d[0] = acc_s;
      for (int k = 1; k < MUL_LATENCY; k++) begin
         q_pipe_d[k] = q_pipe_q[k-1];
         v_pipe_d[k] = v_pipe_q[k-1];
      end
   end

   // Output nibble: product plus aligned square-scale term, zero when idle.
   always_comb begin
      out_valid_d = v_pipe_q[MUL_LATENCY-1];
      if (v_pipe_q[MUL_LATENCY-1]) begin
         d_d = io._MulQxDI ^ q_pipe_q[MUL_LATENCY-1];
      end else begin
         d_d = '0;
      end
   end

   // Consumed-randomness counter, saturating at all ones.
   always_comb begin
      if (acc_s && (rand_cnt_q != 16'hFFFF)) begin
         rand_cnt_d = rand_cnt_q + 16'd1;
      end else begin
         rand_cnt_d = rand_cnt_q;
      end
   end

   // State registers; reset discards everything in flight.
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         for (int k = 0; k < MUL_LATENCY; k++) begin
            q_pipe_q[k] <= '0;
         end
         v_pipe_q    <= '0;
         d_q         <= '0;
         out_valid_q <= 1'b0;
         rand_cnt_q  <= 16'd0;
      end else begin
         for (int k = 0; k < MUL_LATENCY; k++) begin
            q_pipe_q[k] <= q_pipe_d[k];
         end
         v_pipe_q    <= v_pipe_d;
         d_q         <= d_d;
         out_valid_q <= out_valid_d;
         rand_cnt_q  <= rand_cnt_d;
      end
   end
endmodule
